// File: rtl/video_timing_gen_if.sv
// Configuration and timing-output bundle for video_timing_gen.
// cfg_load is a one-cycle strobe with no back-pressure: it is always sampled, and the
// outcome is reported one cycle later as cfg_pending (accepted) or a cfg_err pulse (rejected).
interface video_timing_gen_if #(
  parameter int X_W  = 12,
  parameter int Y_W  = 11,
  parameter int FC_W = 16
);
  logic            cfg_load;
  logic [X_W-1:0]  cfg_h_active;
  logic [X_W-1:0]  cfg_h_fp;
  logic [X_W-1:0]  cfg_h_sync;
  logic [X_W-1:0]  cfg_h_bp;
  logic [Y_W-1:0]  cfg_v_active;
  logic [Y_W-1:0]  cfg_v_fp;
  logic [Y_W-1:0]  cfg_v_sync;
  logic [Y_W-1:0]  cfg_v_bp;
  logic            cfg_hs_pol;
  logic            cfg_vs_pol;
  logic            cfg_pending;
  logic            cfg_err;
  logic [X_W-1:0]  counterX;
  logic [Y_W-1:0]  counterY;
  logic            de;
  logic            hsync;
  logic            vsync;
  logic            line_start;
  logic            frame_start;
  logic [FC_W-1:0] frame_count;

  modport master (
    output cfg_load, cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
           cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_hs_pol, cfg_vs_pol,
    input  cfg_pending, cfg_err, counterX, counterY, de, hsync, vsync,
           line_start, frame_start, frame_count
  );

  modport slave (
    input  cfg_load, cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
           cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_hs_pol, cfg_vs_pol,
    output cfg_pending, cfg_err, counterX, counterY, de, hsync, vsync,
           line_start, frame_start, frame_count
  );
endinterface

// File: rtl/video_timing_gen.sv
// Runtime-reprogrammable video timing generator: pixel/line counters, DE, syncs, strobes,
// frame counter. New timings are staged in a shadow set and swapped in at the frame wrap.
module video_timing_gen #(
  parameter int X_W      = 12,
  parameter int Y_W      = 11,
  parameter int FC_W     = 16,
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1
) (
  input  logic            clk_pix,
  input  logic            rst,
  video_timing_gen_if.slave bus
);

  // Two spare bits so a sum of four maximal fields can never alias into range.
  localparam int XT = X_W + 2;
  localparam int YT = Y_W + 2;

  localparam logic [X_W-1:0] X_RST = X_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [Y_W-1:0] Y_RST = Y_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  typedef struct packed {
    logic [X_W-1:0] h_act;
    logic [X_W-1:0] h_fp;
    logic [X_W-1:0] h_sync;
    logic [X_W-1:0] h_bp;
    logic [Y_W-1:0] v_act;
    logic [Y_W-1:0] v_fp;
    logic [Y_W-1:0] v_sync;
    logic [Y_W-1:0] v_bp;
    logic           hs_pol;
    logic           vs_pol;
  } timing_t;

  function automatic timing_t reset_timing();
    timing_t t;
    t.h_act  = X_W'(H_ACTIVE);
    t.h_fp   = X_W'(H_FP);
    t.h_sync = X_W'(H_SYNC);
    t.h_bp   = X_W'(H_BP);
    t.v_act  = Y_W'(V_ACTIVE);
    t.v_fp   = Y_W'(V_FP);
    t.v_sync = Y_W'(V_SYNC);
    t.v_bp   = Y_W'(V_BP);
    t.hs_pol = 1'(HS_POL);
    t.vs_pol = 1'(VS_POL);
    return t;
  endfunction

  function automatic logic [XT-1:0] h_total(timing_t t);
    return XT'(t.h_act) + XT'(t.h_fp) + XT'(t.h_sync) + XT'(t.h_bp);
  endfunction

  function automatic logic [YT-1:0] v_total(timing_t t);
    return YT'(t.v_act) + YT'(t.v_fp) + YT'(t.v_sync) + YT'(t.v_bp);
  endfunction

  timing_t         cur_t;
  timing_t         shd_t;
  timing_t         nxt_t;
  timing_t         cfg_t;
  logic [X_W-1:0]  counter_x;
  logic [Y_W-1:0]  counter_y;
  logic [X_W-1:0]  nx;
  logic [Y_W-1:0]  ny;
  logic [XT-1:0]   cur_hlast;
  logic [YT-1:0]   cur_vlast;
  logic [XT-1:0]   cfg_htot;
  logic [YT-1:0]   cfg_vtot;
  logic [XT-1:0]   hs_lo;
  logic [XT-1:0]   hs_hi;
  logic [YT-1:0]   vs_lo;
  logic [YT-1:0]   vs_hi;
  logic            eol;
  logic            eof;
  logic            wrap;
  logic            apply;
  logic            cfg_ok;
  logic            de_n;
  logic            hs_n;
  logic            vs_n;
  logic            pending_q;
  logic            err_q;
  logic            de_q;
  logic            hs_q;
  logic            vs_q;
  logic            ls_q;
  logic            fs_q;
  logic [FC_W-1:0] fc_q;

  always_comb begin
    cfg_t        = '0;
    cfg_t.h_act  = bus.cfg_h_active;
    cfg_t.h_fp   = bus.cfg_h_fp;
    cfg_t.h_sync = bus.cfg_h_sync;
    cfg_t.h_bp   = bus.cfg_h_bp;
    cfg_t.v_act  = bus.cfg_v_active;
    cfg_t.v_fp   = bus.cfg_v_fp;
    cfg_t.v_sync = bus.cfg_v_sync;
    cfg_t.v_bp   = bus.cfg_v_bp;
    cfg_t.hs_pol = bus.cfg_hs_pol;
    cfg_t.vs_pol = bus.cfg_vs_pol;
  end

  assign cfg_htot = h_total(cfg_t);
  assign cfg_vtot = v_total(cfg_t);
  assign cfg_ok   = (cfg_t.h_act != '0) && (cfg_t.h_sync != '0) &&
                    (cfg_t.v_act != '0) && (cfg_t.v_sync != '0) &&
                    (cfg_htot[XT-1:X_W] == '0) && (cfg_vtot[YT-1:Y_W] == '0);

  assign cur_hlast = h_total(cur_t) - XT'(1);
  assign cur_vlast = v_total(cur_t) - YT'(1);
  assign eol       = (XT'(counter_x) == cur_hlast);
  assign eof       = (YT'(counter_y) == cur_vlast);
  assign wrap      = eol && eof;
  assign apply     = wrap && pending_q;

  // Outputs are computed for the position entering the counters, using the timing that
  // will be live there, so the (0,0) pixel after an apply already sees the new set.
  assign nxt_t = apply ? shd_t : cur_t;
  assign nx    = eol ? '0 : counter_x + X_W'(1);
  assign ny    = eol ? (eof ? '0 : counter_y + Y_W'(1)) : counter_y;

  assign hs_lo = XT'(nxt_t.h_act) + XT'(nxt_t.h_fp);
  assign hs_hi = hs_lo + XT'(nxt_t.h_sync);
  assign vs_lo = YT'(nxt_t.v_act) + YT'(nxt_t.v_fp);
  assign vs_hi = vs_lo + YT'(nxt_t.v_sync);

  assign de_n = (nx < nxt_t.h_act) && (ny < nxt_t.v_act);
  assign hs_n = ((XT'(nx) >= hs_lo) && (XT'(nx) < hs_hi)) ? nxt_t.hs_pol : !nxt_t.hs_pol;
  assign vs_n = ((YT'(ny) >= vs_lo) && (YT'(ny) < vs_hi)) ? nxt_t.vs_pol : !nxt_t.vs_pol;

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      cur_t     <= reset_timing();
      shd_t     <= reset_timing();
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      counter_x <= X_RST;
      counter_y <= Y_RST;
      de_q      <= 1'b0;
      hs_q      <= !1'(HS_POL);
      vs_q      <= !1'(VS_POL);
      ls_q      <= 1'b0;
      fs_q      <= 1'b0;
      fc_q      <= '0;
    end else begin
      counter_x <= nx;
      counter_y <= ny;
      de_q      <= de_n;
      hs_q      <= hs_n;
      vs_q      <= vs_n;
      ls_q      <= (nx == '0);
      fs_q      <= wrap;
      if (wrap) fc_q <= fc_q + FC_W'(1);
      if (apply) begin
        cur_t     <= shd_t;
        pending_q <= 1'b0;
      end
      // A load on the wrap edge lands after the apply, so it stays pending for a frame.
      err_q <= 1'b0;
      if (bus.cfg_load) begin
        if (cfg_ok) begin
          shd_t     <= cfg_t;
          pending_q <= 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.cfg_pending = pending_q;
  assign bus.cfg_err     = err_q;
  assign bus.counterX    = counter_x;
  assign bus.counterY    = counter_y;
  assign bus.de          = de_q;
  assign bus.hsync       = hs_q;
  assign bus.vsync       = vs_q;
  assign bus.line_start  = ls_q;
  assign bus.frame_start = fs_q;
  assign bus.frame_count = fc_q;

endmodule
